// File: rtl/awmc_pkg.sv
// awmc_pkg: stage and mode encodings plus duration helpers for the
// programmable washing-machine controller (awmc_prog).
package awmc_pkg;

    typedef enum logic [2:0] {
        ST_FILL  = 3'b000,
        ST_WASH  = 3'b001,
        ST_RINSE = 3'b010,
        ST_SPIN  = 3'b011,
        ST_STOP  = 3'b100,
        ST_PAUSE = 3'b101,
        ST_DRAIN = 3'b110,
        ST_IDLE  = 3'b111
    } stage_e;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_QUICK  = 2'd1,
        MODE_HEAVY  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Wash length in cycles; heavy doubles and saturates at the timer full scale.
    function automatic int wash_dur(input logic [1:0] mode, input int wash_t, input int cnt_w);
        int full;
        full = (1 << cnt_w) - 1;
        case (mode)
            MODE_QUICK: wash_dur = wash_t >> 1;
            MODE_HEAVY: wash_dur = ((wash_t << 1) > full) ? full : (wash_t << 1);
            default:    wash_dur = wash_t;
        endcase
    endfunction

    // Index of the final rinse pass: 0 requests count as 1, heavy adds a pass,
    // and the total is clamped to the machine maximum.
    function automatic logic [1:0] rinse_last(input logic [1:0] mode, input logic [1:0] req,
                                              input int max_rinse);
        int n;
        n = (req == 2'd0) ? 1 : int'(req);
        if (mode == MODE_HEAVY) n = n + 1;
        if (n > max_rinse) n = max_rinse;
        rinse_last = 2'(n - 1);
    endfunction

endpackage

// File: rtl/awmc_if.sv
// awmc_if: signal bundle between the front panel (master) and awmc_prog (slave).
// The abort line is present only when AWMC_ABORT_EN is defined.
interface awmc_if #(parameter int CNT_W = 8);
`ifdef AWMC_ABORT_EN
    logic             abort;
`endif
    logic             start;
    logic             pause;
    logic             lid;
    logic [1:0]       mode;
    logic [1:0]       rinse_cnt;
    logic [2:0]       stage;
    logic             done;
    logic             input_valve;
    logic             output_drain;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       rinse_idx;

    modport master (
`ifdef AWMC_ABORT_EN
        output abort,
`endif
        output start, pause, lid, mode, rinse_cnt,
        input  stage, done, input_valve, output_drain, remaining, rinse_idx
    );

    modport slave (
`ifdef AWMC_ABORT_EN
        input  abort,
`endif
        input  start, pause, lid, mode, rinse_cnt,
        output stage, done, input_valve, output_drain, remaining, rinse_idx
    );
endinterface

// File: rtl/awmc_stage_timer.sv
// awmc_stage_timer: loadable down-counter for stage timing. Load wins over
// hold; the count stops at zero. cnt_nxt exposes the value the counter takes
// at the next edge so registered outputs can be derived from it.
module awmc_stage_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, freeze, or decrement toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
    assign zero    = (cnt_q == '0);
endmodule

// File: rtl/awmc_prog.sv
// awmc_prog: programmable washing-machine controller.
// FILL -> WASH -> RINSE (1..MAX_RINSE passes) -> SPIN -> STOP -> IDLE, with
// pause / lid-open suspend and resume. All outputs are registered.
// Optional: define AWMC_ABORT_EN to add an abort input that drains for
// DRAIN_T cycles and returns to IDLE without setting done.
module awmc_prog
    import awmc_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int FILL_T    = 4,
    parameter int WASH_T    = 8,
    parameter int RINSE_T   = 6,
    parameter int SPIN_T    = 6,
    parameter int DRAIN_T   = 2,
    parameter int MAX_RINSE = 3
) (
    input  logic   clk,
    input  logic   reset,
    awmc_if.slave  bus
);
    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_T - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_T - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_T - 1);
    // Remaining values at or above this mark fall in the drain part of a rinse pass.
    localparam logic [CNT_W-1:0] DRN_TH   = CNT_W'(RINSE_T - DRAIN_T);

    stage_e           stage_q, stage_d;
    stage_e           sav_q, sav_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             valve_q, valve_d;
    logic             drain_q, drain_d;

    logic             tm_load;
    logic [CNT_W-1:0] tm_val;
    logic             tm_hold;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_nxt;
    logic             rem_zero;
    logic [CNT_W-1:0] wash_ld;
    logic             abort_req;
    logic             suspend;

`ifdef AWMC_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign suspend = bus.pause || !bus.lid;
    assign wash_ld = CNT_W'(wash_dur(mode_q, WASH_T, CNT_W) - 1);

    awmc_stage_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tm_load),
        .load_val (tm_val),
        .hold     (tm_hold),
        .cnt      (rem),
        .cnt_nxt  (rem_nxt),
        .zero     (rem_zero)
    );

    // Stage sequencing, context save/restore and timer control.
    always_comb begin
        stage_d = stage_q;
        sav_d   = sav_q;
        mode_d  = mode_q;
        last_d  = last_q;
        idx_d   = idx_q;
        done_d  = done_q;
        tm_load = 1'b0;
        tm_val  = '0;
        tm_hold = 1'b1;
        case (stage_q)
            ST_IDLE: begin
                if (bus.start && bus.lid && !bus.pause) begin
                    stage_d = ST_FILL;
                    mode_d  = bus.mode;
                    last_d  = rinse_last(bus.mode, bus.rinse_cnt, MAX_RINSE);
                    idx_d   = '0;
                    done_d  = 1'b0;
                    tm_load = 1'b1;
                    tm_val  = FILL_LD;
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (abort_req) begin
                    stage_d = ST_DRAIN;
                    done_d  = 1'b0;
                    tm_load = 1'b1;
                    tm_val  = DRAIN_LD;
                end else if (suspend) begin
                    stage_d = ST_PAUSE;
                    sav_d   = stage_q;
                end else if (rem_zero) begin
                    tm_load = 1'b1;
                    case (stage_q)
                        ST_FILL: begin
                            stage_d = ST_WASH;
                            tm_val  = wash_ld;
                        end
                        ST_WASH: begin
                            stage_d = ST_RINSE;
                            idx_d   = '0;
                            tm_val  = RINSE_LD;
                        end
                        ST_RINSE: begin
                            if (idx_q == last_q) begin
                                stage_d = ST_SPIN;
                                tm_val  = SPIN_LD;
                            end else begin
                                idx_d  = idx_q + 2'd1;
                                tm_val = RINSE_LD;
                            end
                        end
                        default: begin
                            stage_d = ST_STOP;
                            done_d  = 1'b1;
                            tm_val  = '0;
                        end
                    endcase
                end else begin
                    tm_hold = 1'b0;
                end
            end
            ST_STOP: begin
                stage_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (abort_req) begin
                    stage_d = ST_DRAIN;
                    done_d  = 1'b0;
                    tm_load = 1'b1;
                    tm_val  = DRAIN_LD;
                end else if (bus.start && !bus.pause && bus.lid) begin
                    stage_d = sav_q;
                end
            end
            ST_DRAIN: begin
                if (rem_zero) begin
                    stage_d = ST_IDLE;
                    done_d  = 1'b0;
                end else begin
                    tm_hold = 1'b0;
                end
            end
            default: begin
                stage_d = ST_IDLE;
            end
        endcase
    end

    // Valve and pump levels for the stage and timer value about to be registered.
    always_comb begin
        valve_d = 1'b0;
        drain_d = 1'b0;
        case (stage_d)
            ST_FILL:  valve_d = 1'b1;
            ST_RINSE: begin
                if (rem_nxt >= DRN_TH) drain_d = 1'b1;
                else                   valve_d = 1'b1;
            end
            ST_SPIN, ST_DRAIN: drain_d = 1'b1;
            default: ;
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= ST_IDLE;
            sav_q   <= ST_IDLE;
            mode_q  <= 2'd0;
            last_q  <= 2'd0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            valve_q <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            sav_q   <= sav_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            valve_q <= valve_d;
            drain_q <= drain_d;
        end
    end

    assign bus.stage        = stage_q;
    assign bus.done         = done_q;
    assign bus.input_valve  = valve_q;
    assign bus.output_drain = drain_q;
    assign bus.remaining    = rem;
    assign bus.rinse_idx    = idx_q;
endmodule

// File: tb/tb_awmc_prog.sv
// tb_awmc_prog: self-checking bench for awmc_prog. Expected behaviour comes
// from a per-cycle trace built directly from the stage durations and rules.
module tb_awmc_prog;
    localparam int CNT_W     = 8;
    localparam int FILL_T    = 4;
    localparam int WASH_T    = 8;
    localparam int RINSE_T   = 6;
    localparam int SPIN_T    = 6;
    localparam int DRAIN_T   = 2;
    localparam int MAX_RINSE = 3;

    localparam logic [2:0] S_FILL  = 3'b000;
    localparam logic [2:0] S_WASH  = 3'b001;
    localparam logic [2:0] S_RINSE = 3'b010;
    localparam logic [2:0] S_SPIN  = 3'b011;
    localparam logic [2:0] S_STOP  = 3'b100;
    localparam logic [2:0] S_PAUSE = 3'b101;
    localparam logic [2:0] S_DRAIN = 3'b110;
    localparam logic [2:0] S_IDLE  = 3'b111;

    typedef struct {
        logic [2:0]       st;
        logic [CNT_W-1:0] rem;
        logic             v;
        logic             d;
        logic             dn;
        logic [1:0]       idx;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    obs_t tr[$];

    awmc_if #(.CNT_W(CNT_W)) bus();

    awmc_prog #(
        .CNT_W(CNT_W), .FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
        .SPIN_T(SPIN_T), .DRAIN_T(DRAIN_T), .MAX_RINSE(MAX_RINSE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

    function automatic obs_t mk(input logic [2:0] st, input int rem, input bit v, input bit d,
                                input bit dn, input int idx);
        obs_t o;
        o.st = st; o.rem = CNT_W'(rem); o.v = v; o.d = d; o.dn = dn; o.idx = 2'(idx);
        return o;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.stage, bus.done, bus.input_valve, bus.output_drain, bus.remaining, bus.rinse_idx}
            !== {S_IDLE, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_hold got st=%b dn=%b v=%b d=%b rem=%0d idx=%0d want st=111 all zero",
                     bus.stage, bus.done, bus.input_valve, bus.output_drain, bus.remaining, bus.rinse_idx);
        end
        reset = 1'b0;
        tick();
        total++;
        if ({bus.stage, bus.done, bus.remaining} !== {S_IDLE, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_release got st=%b dn=%b rem=%0d want st=111 dn=0 rem=0",
                     bus.stage, bus.done, bus.remaining);
        end
    endtask

    // One full programme with optional random suspends/resumes, checked cycle by cycle.
    task automatic test_program(input int md, input int rc, input int susp);
        obs_t exp_o;
        int   w, np, k, r, guard;
        bit   paused;
        w  = (md == 1) ? (WASH_T >> 1) : (md == 2) ? (((WASH_T << 1) > 255) ? 255 : (WASH_T << 1)) : WASH_T;
        np = (rc == 0) ? 1 : rc;
        if (md == 2) np++;
        if (np > MAX_RINSE) np = MAX_RINSE;
        tr.delete();
        for (int c = 0; c < FILL_T; c++) tr.push_back(mk(S_FILL, FILL_T - 1 - c, 1, 0, 0, 0));
        for (int c = 0; c < w; c++)      tr.push_back(mk(S_WASH, w - 1 - c, 0, 0, 0, 0));
        for (int p = 0; p < np; p++)
            for (int c = 0; c < RINSE_T; c++)
                tr.push_back(mk(S_RINSE, RINSE_T - 1 - c, c >= DRAIN_T, c < DRAIN_T, 0, p));
        for (int c = 0; c < SPIN_T; c++) tr.push_back(mk(S_SPIN, SPIN_T - 1 - c, 0, 1, 0, np - 1));
        tr.push_back(mk(S_STOP, 0, 0, 0, 1, np - 1));
        tr.push_back(mk(S_IDLE, 0, 0, 0, 1, np - 1));

        bus.mode = 2'(md); bus.rinse_cnt = 2'(rc);
        bus.start = 1'b1; bus.pause = 1'b0; bus.lid = 1'b1;
        tick();
        bus.start = 1'b0; bus.mode = 2'($urandom); bus.rinse_cnt = 2'($urandom);
        k = 0; paused = 0;
        for (guard = 0; guard < 3000; guard++) begin
            exp_o = paused ? mk(S_PAUSE, int'(tr[k].rem), 0, 0, 0, int'(tr[k].idx)) : tr[k];
            total++;
            if ({bus.stage, bus.remaining, bus.input_valve, bus.output_drain, bus.done, bus.rinse_idx}
                !== {exp_o.st, exp_o.rem, exp_o.v, exp_o.d, exp_o.dn, exp_o.idx}) begin
                bad++;
                $display("FAIL prog md=%0d rc=%0d step=%0d got st=%b rem=%0d v=%b d=%b dn=%b idx=%0d want st=%b rem=%0d v=%b d=%b dn=%b idx=%0d",
                         md, rc, guard, bus.stage, bus.remaining, bus.input_valve, bus.output_drain,
                         bus.done, bus.rinse_idx, exp_o.st, exp_o.rem, exp_o.v, exp_o.d, exp_o.dn, exp_o.idx);
            end
            if (!paused && exp_o.st == S_IDLE) break;
            if (paused) begin
                r = int'($urandom_range(0, 3));
                bus.start = (r != 3); bus.pause = (r == 1); bus.lid = (r != 2);
                if (r == 0) paused = 0;
            end else if (exp_o.st != S_STOP && int'($urandom_range(0, 99)) < susp) begin
                bus.start = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 1) == 1) begin bus.pause = 1'b1; bus.lid = 1'b1; end
                else                           begin bus.pause = 1'b0; bus.lid = 1'b0; end
                paused = 1;
            end else begin
                bus.start = ($urandom_range(0, 1) == 1); bus.pause = 1'b0; bus.lid = 1'b1;
                k++;
            end
            tick();
        end
        if (guard >= 3000) begin
            total++; bad++;
            $display("FAIL prog_budget md=%0d rc=%0d got no IDLE want IDLE within 3000 cycles", md, rc);
        end
        bus.start = 1'b0; bus.pause = 1'b0; bus.lid = 1'b1;
    endtask

    task automatic test_pause_wash();
        bus.mode = 2'd0; bus.rinse_cnt = 2'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        total++;
        if ({bus.stage, bus.remaining} !== {S_WASH, 8'd5}) begin
            bad++; $display("FAIL pw_pre got st=%b rem=%0d want st=001 rem=5", bus.stage, bus.remaining);
        end
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i >= 5);
            tick();
            total++;
            if ({bus.stage, bus.remaining, bus.input_valve, bus.output_drain} !== {S_PAUSE, 8'd5, 2'b00}) begin
                bad++; $display("FAIL pw_hold i=%0d got st=%b rem=%0d v=%b d=%b want st=101 rem=5 v=0 d=0",
                                i, bus.stage, bus.remaining, bus.input_valve, bus.output_drain);
            end
        end
        bus.start = 1'b0; bus.pause = 1'b0; bus.lid = 1'b0;
        tick();
        total++;
        if ({bus.stage, bus.remaining} !== {S_PAUSE, 8'd5}) begin
            bad++; $display("FAIL pw_lid got st=%b rem=%0d want st=101 rem=5", bus.stage, bus.remaining);
        end
        bus.lid = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int d = 5; d >= 0; d--) begin
            total++;
            if ({bus.stage, bus.remaining} !== {S_WASH, 8'(d)}) begin
                bad++; $display("FAIL pw_resume got st=%b rem=%0d want st=001 rem=%0d", bus.stage, bus.remaining, d);
            end
            tick();
        end
        total++;
        if ({bus.stage, bus.remaining, bus.output_drain} !== {S_RINSE, 8'd5, 1'b1}) begin
            bad++; $display("FAIL pw_rinse got st=%b rem=%0d d=%b want st=010 rem=5 d=1",
                            bus.stage, bus.remaining, bus.output_drain);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        bus.mode = 2'd0; bus.rinse_cnt = 2'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        total++;
        if ({bus.stage, bus.remaining, bus.input_valve} !== {S_RINSE, 8'd3, 1'b1}) begin
            bad++; $display("FAIL rm_pre got st=%b rem=%0d v=%b want st=010 rem=3 v=1",
                            bus.stage, bus.remaining, bus.input_valve);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.stage, bus.input_valve, bus.output_drain, bus.done, bus.remaining, bus.rinse_idx}
            !== {S_IDLE, 3'b000, 8'd0, 2'd0}) begin
            bad++; $display("FAIL rm_async got st=%b v=%b d=%b dn=%b rem=%0d want st=111 all zero",
                            bus.stage, bus.input_valve, bus.output_drain, bus.done, bus.remaining);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lid_spin();
        bus.mode = 2'd1; bus.rinse_cnt = 2'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (15) tick();
        total++;
        if ({bus.stage, bus.remaining, bus.output_drain} !== {S_SPIN, 8'd4, 1'b1}) begin
            bad++; $display("FAIL ls_pre got st=%b rem=%0d d=%b want st=011 rem=4 d=1",
                            bus.stage, bus.remaining, bus.output_drain);
        end
        bus.lid = 1'b0;
        tick();
        total++;
        if ({bus.stage, bus.remaining, bus.output_drain} !== {S_PAUSE, 8'd4, 1'b0}) begin
            bad++; $display("FAIL ls_open got st=%b rem=%0d d=%b want st=101 rem=4 d=0",
                            bus.stage, bus.remaining, bus.output_drain);
        end
        bus.lid = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if ({bus.stage, bus.remaining, bus.output_drain} !== {S_SPIN, 8'd4, 1'b1}) begin
            bad++; $display("FAIL ls_resume got st=%b rem=%0d d=%b want st=011 rem=4 d=1",
                            bus.stage, bus.remaining, bus.output_drain);
        end
        repeat (5) tick();
        total++;
        if ({bus.stage, bus.done} !== {S_STOP, 1'b1}) begin
            bad++; $display("FAIL ls_stop got st=%b dn=%b want st=100 dn=1", bus.stage, bus.done);
        end
        repeat (3) tick();
        total++;
        if ({bus.stage, bus.done} !== {S_IDLE, 1'b1}) begin
            bad++; $display("FAIL ls_idle got st=%b dn=%b want st=111 dn=1", bus.stage, bus.done);
        end
    endtask

    task automatic test_start_ignored();
        bus.start = 1'b1; bus.lid = 1'b0; bus.pause = 1'b0;
        repeat (2) tick();
        total++;
        if ({bus.stage, bus.done, bus.input_valve} !== {S_IDLE, 1'b1, 1'b0}) begin
            bad++; $display("FAIL si_lid got st=%b dn=%b v=%b want st=111 dn=1 v=0",
                            bus.stage, bus.done, bus.input_valve);
        end
        bus.lid = 1'b1; bus.pause = 1'b1;
        tick();
        total++;
        if ({bus.stage, bus.done} !== {S_IDLE, 1'b1}) begin
            bad++; $display("FAIL si_pause got st=%b dn=%b want st=111 dn=1", bus.stage, bus.done);
        end
        bus.start = 1'b0; bus.pause = 1'b0;
        tick();
    endtask

`ifdef AWMC_ABORT_EN
    task automatic test_abort();
        bus.mode = 2'd0; bus.rinse_cnt = 2'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if ({bus.stage, bus.remaining, bus.output_drain, bus.input_valve} !== {S_DRAIN, 8'd1, 2'b10}) begin
            bad++; $display("FAIL ab_drain1 got st=%b rem=%0d d=%b v=%b want st=110 rem=1 d=1 v=0",
                            bus.stage, bus.remaining, bus.output_drain, bus.input_valve);
        end
        tick();
        total++;
        if ({bus.stage, bus.remaining, bus.output_drain} !== {S_DRAIN, 8'd0, 1'b1}) begin
            bad++; $display("FAIL ab_drain2 got st=%b rem=%0d d=%b want st=110 rem=0 d=1",
                            bus.stage, bus.remaining, bus.output_drain);
        end
        tick();
        total++;
        if ({bus.stage, bus.done, bus.output_drain} !== {S_IDLE, 1'b0, 1'b0}) begin
            bad++; $display("FAIL ab_idle got st=%b dn=%b d=%b want st=111 dn=0 d=0",
                            bus.stage, bus.done, bus.output_drain);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.stage !== S_IDLE) begin
            bad++; $display("FAIL ab_in_idle got st=%b want st=111", bus.stage);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.pause = 1'b1;
        tick();
        bus.pause = 1'b0; bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if ({bus.stage, bus.output_drain} !== {S_DRAIN, 1'b1}) begin
            bad++; $display("FAIL ab_pause got st=%b d=%b want st=110 d=1", bus.stage, bus.output_drain);
        end
        repeat (2) tick();
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.lid = 1'b1;
        bus.mode = 2'd0; bus.rinse_cnt = 2'd0;
`ifdef AWMC_ABORT_EN
        bus.abort = 1'b0;
`endif
        reset = 1'b1;
        test_reset();
        test_program(0, 1, 0);
        test_program(1, 2, 0);
        test_program(2, 3, 0);
        test_program(3, 0, 0);
        test_pause_wash();
        test_reset_mid();
        test_lid_spin();
        test_start_ignored();
`ifdef AWMC_ABORT_EN
        test_abort();
`endif
        for (int i = 0; i < 8; i++)
            test_program(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/awmc_prog.md
Name: awmc_prog

Overview:
Programmable washing-machine controller; successor to the fixed-timing controller in the same appliance-control tree. It sequences FILL -> WASH -> RINSE (1..MAX_RINSE passes) -> SPIN -> STOP. Stage durations are parameters, and a wash mode scales the wash time. Pause and lid-open events suspend the cycle and preserve the remaining stage time. It exposes the current stage, rinse pass index and remaining stage time to the front-panel logic.

Parameters:
CNT_W, 8, width of stage timer and remaining output
FILL_T, 4, FILL duration in cycles (>=1)
WASH_T, 8, nominal WASH duration in cycles (>=2)
RINSE_T, 6, duration of one rinse pass in cycles (>DRAIN_T)
SPIN_T, 6, SPIN duration in cycles (>=1)
DRAIN_T, 2, drain sub-phase length at the start of each rinse pass
MAX_RINSE, 3, maximum rinse passes (1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; starts a cycle from IDLE, or resumes from PAUSE
pause  in  1  level; suspends an active cycle
lid  in  1  1 = lid closed, 0 = lid open
mode  in  2  0 normal, 1 quick (WASH_T>>1), 2 heavy (WASH_T<<1, +1 rinse), 3 treated as normal
rinse_cnt  in  2  requested rinse passes; 0 treated as 1; clamped to MAX_RINSE
stage  out  3  IDLE=111, FILL=000, WASH=001, RINSE=010, SPIN=011, STOP=100, PAUSE=101, DRAIN=110
done  out  1  cycle complete flag
input_valve  out  1  water inlet
output_drain  out  1  drain pump
remaining  out  CNT_W  cycles left in current stage, minus 1
rinse_idx  out  2  current rinse pass, 0-based

Behaviour:
- All outputs are registered. On reset (async), and in IDLE after reset: stage=IDLE, done=0, valves=0, remaining=0, rinse_idx=0, saved context cleared. Reset mid-cycle forces all of these immediately; there is no drain-out on reset.
- Start: in IDLE, start=1 & lid=1 & pause=0 at edge n gives stage=FILL at n+1. At the same edge, mode and rinse passes are latched, and done is cleared. Start with lid=0 is ignored. Start in an active stage is ignored.
- Timer: on stage entry, remaining = duration-1. It decrements each active cycle. When remaining==0, the next edge advances the stage, so each stage lasts exactly its duration.
- Wash duration by mode: normal = WASH_T; quick = WASH_T>>1; heavy = WASH_T<<1, saturating to 2^CNT_W-1.
- Rinse passes: latched value (0 -> 1); heavy adds 1; result clamped to MAX_RINSE. After the last pass, go to SPIN; otherwise stay in RINSE, increment rinse_idx and reload the timer.
- Outputs per stage: FILL valve=1, drain=0. WASH both 0. RINSE: drain=1 for the first DRAIN_T cycles of each pass, then valve=1 for the rest. SPIN drain=1. STOP, IDLE, PAUSE both 0.
- STOP lasts one cycle. done is set entering STOP and held through IDLE until the next accepted start or reset. Stage then returns to IDLE.
- Suspend: pause=1, or lid=0, in FILL/WASH/RINSE/SPIN gives stage=PAUSE at the next edge. The suspended stage, remaining and rinse_idx are saved and frozen; valves go 0.
- Resume: in PAUSE, start=1 & pause=0 & lid=1 returns to the saved stage with the frozen remaining value. Decrementing resumes on the following cycle.
- Priority at one edge: reset > abort > pause/lid-open > remaining==0 advance > start. Pause and start together: pause wins.
- In IDLE, lid and pause are don't-care.

Optional Feature:
AWMC_ABORT_EN
- Defined: adds input abort (1 bit). Abort=1 in any active stage or PAUSE goes to DRAIN (110) with drain=1 and valves off for DRAIN_T cycles, then IDLE with done=0. Abort is ignored in IDLE, STOP and DRAIN.
- Undefined: no abort port; DRAIN is unreachable.

Decomposition:
- Package awmc_pkg holds the stage encodings, the mode encodings and a wash-duration function (mode, WASH_T, CNT_W).
- One sub-module, awmc_stage_timer: a loadable down-counter with load, hold and zero flag, width CNT_W.

Test Plan:
- Defaults, mode 0, rinse_cnt=1, start at edge 0: FILL edges 1-4 (valve=1), WASH 5-12, RINSE 13-18 (drain 13-14, valve 15-18), SPIN 19-24, STOP 25. done=1 from 25 and held in IDLE.
- Mode 1, rinse_cnt=2: WASH lasts 4 cycles (5-8). RINSE passes 9-14 (rinse_idx=0) and 15-20 (rinse_idx=1). SPIN 21-26, STOP 27.
- Mode 2, rinse_cnt=3: wash 16 cycles; rinse passes clamp to 3; rinse_idx reaches 2, never 3.
- Pause in WASH when remaining=5: stage=PAUSE next edge and remaining stays 5 for 10 cycles. Lid opened then closed plus start: return to WASH with remaining=5, then 5 more decrements to RINSE. Start while pause=1 stays in PAUSE.
- Lid=0 during SPIN: stage -> PAUSE and drain=0. Start with lid=0 in IDLE: stage stays IDLE.
- Reset asserted mid-RINSE with valve=1: immediately stage=IDLE, valves=0, done=0. With AWMC_ABORT_EN, abort in WASH gives DRAIN for 2 cycles, then IDLE with done=0.
